alu_181_seq: RTL
================

# alu_181_seq

Sequential, width-parametrised successor to the combinational 4-bit 74181 ALU cell. It evaluates a WIDTH-bit 74181-style operation one nibble per clock, least significant nibble first, rippling the carry through a register. It returns registered F, carry-out, A=B and group G/P, with a start/ready/done handshake. It sits beside the existing `alu_74181` cell as the wide, area-lean datapath ALU, using the same A/B/S/M/Cn/F/G/P/E/Cn4 semantics.

## Interface
- WIDTH, 16, operand width in bits; must be a multiple of 4 and at least 4. NIB = WIDTH/4, derived.
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  request; sampled only when ready=1.
- ready  out  1  high in IDLE and DONE; start is accepted in either state.
- A  in  WIDTH  operand A; captured at accept.
- B  in  WIDTH  operand B; captured at accept.
- S  in  4  function select; captured at accept.
- M  in  1  mode: 1 = logic, 0 = arithmetic; captured at accept.
- Cn  in  1  carry-in, active-low (1 = no carry); captured at accept.
- F  out  WIDTH  result; registered, held until the next result.
- Cn4  out  1  carry-out of the top nibble, active-low.
- E  out  1  high when F is all ones.
- G  out  1  group generate, active-low.
- P  out  1  group propagate, active-low.
- done  out  1  one-cycle pulse; result valid.

## Operation
- FSM states: IDLE, RUN, DONE. Reset enters IDLE.
- IDLE or DONE with start=1: capture A, B, S, M and Cn into operand registers. Load the carry register with Cn. Clear the nibble counter k. Go to RUN.
- DONE with start=0: go to IDLE.
- RUN, each cycle:
  - Compute nibble k with the 74181 active-high function set for S/M, using carry-in from the carry register.
  - Write F[4k+3:4k]. Store the nibble carry-out (active-low) in the carry register.
  - Fold the group terms: gacc = g_k | (p_k & gacc); pacc = pacc & p_k. Here g_k and p_k are the active-high nibble generate/propagate.
  - At k = NIB-1, go to DONE. Otherwise k increments.
- DONE: done=1. Outputs are set as follows:
  - Cn4 = the final carry register.
  - G = ~gacc; P = ~pacc.
  - E = &F.
- M=1 (logic mode): the carry is ignored; Cn4, G and P report 1. F is still computed nibble-serially.
- start while in RUN: ignored; no queueing.
- F/Cn4/E/G/P are only updated in DONE. Partial nibble writes go to an internal shadow register, so outputs never show mixed results.
- Reset values: F=0, Cn4=1, E=0, G=1, P=1, done=0, ready=1 (IDLE). Reset also clears the accumulator register when it is configured.
- rst during RUN: the operation is aborted with no done pulse. Outputs take their reset values on the next edge.

## Timing
- Latency: start is accepted at edge t. done is high in the cycle after edge t+NIB, and outputs are valid from that cycle.
- Throughput: with start held high in DONE, a new operation is accepted every NIB+1 cycles.
- ready is a function of state only; it has no combinational path from start.
- All outputs are registered. The critical path is one nibble cell plus the G/P fold.

## Configuration
- ALU181_SEQ_ACC_EN defined: adds port `acc_sel  in  1`, sampled at accept.
  - acc_sel=1: the A operand is the last completed F (0 after reset) instead of port A.
  - acc_sel=0: identical to the macro-undefined behaviour.
- ALU181_SEQ_ACC_EN undefined: there is no acc_sel port and no accumulator logic; port A is always used.

## Test plan
- WIDTH=16, M=0, S=1001, Cn=1, A=0x1234, B=0x0FFF, start -> done exactly 5 cycles after the accept edge; F=0x2233, Cn4=1, E=0.
- M=0, S=1001, Cn=1, A=0xFFFF, B=0x0001 -> F=0x0000, Cn4=0; then the same operands with Cn=0 -> F=0x0001, Cn4=0.
- M=0, S=0110, Cn=1, A=B=0x5A5A -> F=0xFFFF, E=1, Cn4=1; the same with Cn=0 -> F=0x0000, E=0, Cn4=0.
- M=1, S=0110, A=0xF0F0, B=0xFF00 -> F=0x0FF0, Cn4=1, G=1, P=1; start pulsed during RUN is ignored and yields exactly one done.
- Start, then assert rst for 1 cycle in the 2nd RUN cycle -> no done; F=0, Cn4=1, ready=1 after release. A fresh start then completes normally.
- With ALU181_SEQ_ACC_EN: compute F=0x0001, then start with acc_sel=1, S=1001, M=0, Cn=1, B=0x0001 -> F=0x0002; repeat -> F=0x0003.

Source files
------------

// File: rtl/alu_181_seq.sv
// rtl/alu_181_seq.sv - nibble-serial 74181-style ALU with start/ready/done handshake.
// Optional accumulator operand source under `ALU181_SEQ_ACC_EN (adds acc_sel port).
module alu_181_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef ALU181_SEQ_ACC_EN
  input  logic             acc_sel,
`endif
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       S,
  input  logic             M,
  input  logic             Cn,
  output logic             ready,
  output logic [WIDTH-1:0] F,
  output logic             Cn4,
  output logic             E,
  output logic             G,
  output logic             P,
  output logic             done
);

  localparam int NIB = WIDTH / 4;
  localparam int KW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_r, b_r, shadow, sh_next, a_src;
  logic [3:0]       s_r;
  logic             m_r, c_r;
  logic [KW-1:0]    k;
  logic             gacc, pacc;

  logic [3:0]       u, v, f_n;
  logic [4:0]       c;
  logic             g_k, p_k, gacc_next, pacc_next;

`ifdef ALU181_SEQ_ACC_EN
  assign a_src = acc_sel ? F : A;
`else
  assign a_src = A;
`endif

  // Operands shift right each RUN cycle, so the live nibble is always bits [3:0].
  always_comb begin
    u = a_r[3:0] | (b_r[3:0] & {4{s_r[0]}}) | (~b_r[3:0] & {4{s_r[1]}});
    v = (a_r[3:0] & ~b_r[3:0] & {4{s_r[2]}}) | (a_r[3:0] & b_r[3:0] & {4{s_r[3]}});
    c = '0;
    c[0] = ~c_r;
    for (int i = 0; i < 4; i++) begin
      c[i+1] = v[i] | (u[i] & c[i]);
    end
    f_n = m_r ? ~(u ^ v) : (u ^ v ^ c[3:0]);
    g_k = v[3] | (u[3] & v[2]) | (u[3] & u[2] & v[1]) | (u[3] & u[2] & u[1] & v[0]);
    p_k = &u;
    gacc_next = g_k | (p_k & gacc);
    pacc_next = pacc & p_k;
    sh_next = shadow >> 4;
    sh_next[WIDTH-1 -: 4] = f_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ready  <= 1'b1;
      done   <= 1'b0;
      F      <= '0;
      Cn4    <= 1'b1;
      E      <= 1'b0;
      G      <= 1'b1;
      P      <= 1'b1;
      a_r    <= '0;
      b_r    <= '0;
      shadow <= '0;
      s_r    <= '0;
      m_r    <= 1'b0;
      c_r    <= 1'b1;
      k      <= '0;
      gacc   <= 1'b0;
      pacc   <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_r   <= a_src;
            b_r   <= B;
            s_r   <= S;
            m_r   <= M;
            c_r   <= Cn;
            k     <= '0;
            gacc  <= 1'b0;
            pacc  <= 1'b1;
            state <= RUN;
            ready <= 1'b0;
          end else begin
            state <= IDLE;
            ready <= 1'b1;
          end
        end
        RUN: begin
          a_r    <= a_r >> 4;
          b_r    <= b_r >> 4;
          shadow <= sh_next;
          c_r    <= ~c[4];
          gacc   <= gacc_next;
          pacc   <= pacc_next;
          if (k == KW'(NIB - 1)) begin
            state <= DONE;
            ready <= 1'b1;
            done  <= 1'b1;
            F     <= sh_next;
            E     <= &sh_next;
            Cn4   <= m_r | ~c[4];
            G     <= m_r | ~gacc_next;
            P     <= m_r | ~pacc_next;
          end else begin
            k <= k + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
